mem_demux: RTL and testbench
============================

Name: mem_demux

Overview:
- Routes one initiator request/response channel to one of NoPorts target ports, using the index and decode-error flag produced combinationally by the address decoder.
- Tracks outstanding transactions and keeps responses in order by locking onto a single target while any transaction is pending.
- Contains an internal decode-error responder that completes requests to unmapped addresses.
- Sits between the core LSU/IFU bus master and peripheral/memory targets.

Parameters:
- NoPorts, 4, number of target ports (>=1).
- AddrWidth, 32, address width.
- DataWidth, 32, data width.
- MaxTrans, 4, maximum outstanding transactions (>=1).
- ErrData, 32'hBADCAB1E, rdata returned on decode error.
- IdxWidth, max(1,$clog2(NoPorts)), dependent; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  initiator request valid.
- req_ready_o  out  1  initiator request accepted.
- req_addr_i  in  AddrWidth  request address.
- req_we_i  in  1  write enable.
- req_wdata_i  in  DataWidth  write data.
- req_wstrb_i  in  DataWidth/8  byte strobes.
- req_idx_i  in  IdxWidth  decoded target index for req_addr_i.
- req_dec_err_i  in  1  no decoder rule matched.
- rsp_valid_o  out  1  response valid to initiator.
- rsp_ready_i  in  1  initiator accepts response.
- rsp_rdata_o  out  DataWidth  response data.
- rsp_err_o  out  1  response error.
- slv_req_valid_o  out  NoPorts  per-target request valid.
- slv_req_ready_i  in  NoPorts  per-target request ready.
- slv_req_addr_o / slv_req_we_o / slv_req_wdata_o / slv_req_wstrb_o  out  as initiator  broadcast request payload.
- slv_rsp_valid_i  in  NoPorts  per-target response valid.
- slv_rsp_ready_o  out  NoPorts  per-target response ready.
- slv_rsp_rdata_i  in  NoPorts*DataWidth  per-target response data.
- slv_rsp_err_i  in  NoPorts  per-target response error.

Behaviour:
- Clock is clk_i; reset is rst_ni, synchronous, active-low.
- State:
  - cnt: outstanding count, 0..MaxTrans.
  - lock_idx (IdxWidth) and lock_err (1): current target.
  - Reset values: cnt=0, lock_idx=0, lock_err=0.
- Target match: match = (req_dec_err_i ? lock_err : (!lock_err && req_idx_i==lock_idx)).
- Acceptance condition: acc = req_valid_i && (cnt==0 || (match && cnt<MaxTrans)).
- Request forwarding:
  - slv_req_valid_o[req_idx_i] = acc && !req_dec_err_i; all other bits 0.
  - req_ready_o = acc && (req_dec_err_i || slv_req_ready_i[req_idx_i]).
  - Payload is passed through combinationally, zero latency.
- Request handshake (req_valid_i && req_ready_o):
  - lock_idx <= req_idx_i, lock_err <= req_dec_err_i.
  - cnt increments.
- Stall on target switch: a request to a different target waits until cnt==0. While stalled, no slave valid is asserted. Once asserted, a slave valid stays asserted until its handshake, because cnt can only decrease while waiting.
- Response path:
  - If lock_err: rsp_valid_o = (cnt!=0), rsp_rdata_o = ErrData, rsp_err_o = 1. The first error response is valid the cycle after acceptance.
  - Else: rsp_valid_o = slv_rsp_valid_i[lock_idx]; rdata and err come from that port; slv_rsp_ready_o[lock_idx] = rsp_ready_i && cnt!=0.
  - All other slv_rsp_ready_o bits are 0.
- Response handshake decrements cnt. Simultaneous request and response handshakes leave cnt unchanged.
- Bounds:
  - cnt never exceeds MaxTrans; at cnt==MaxTrans, req_ready_o=0.
  - cnt never underflows; with cnt==0, rsp_valid_o=0 and all slv_rsp_ready_o are 0.
- Reset mid-operation: state clears next edge and in-flight transactions are dropped. Targets must be reset together with this block.
- Outputs after reset (req_valid_i=0): req_ready_o=0, rsp_valid_o=0, slv_req_valid_o=0, slv_rsp_ready_o=0.
- Assertions:
  - req_idx_i < NoPorts when !req_dec_err_i.
  - Initiator payload stable while req_valid_i && !req_ready_o.
  - No slave response while cnt==0.

Test Plan:
- Reset, then a single read to idx 2 with slv_req_ready_i[2]=1 and a response 1 cycle later carrying rdata 32'h1234 -> slv_req_valid_o=4'b0100, rsp_rdata_o=32'h1234, rsp_err_o=0, cnt returns to 0.
- Four back-to-back requests to idx 1 with responses held off -> all 4 accepted, 5th stalls (req_ready_o=0), releases the cycle after the first response handshake.
- Request to idx 0 while cnt=2 on idx 3 -> slv_req_valid_o=0 until both idx-3 responses complete, then the idx-0 request issues.
- Request with req_dec_err_i=1 -> req_ready_o=1 same cycle, next cycle rsp_valid_o=1 with rdata 32'hBADCAB1E and rsp_err_o=1, no slave valid asserted.
- Same-cycle request and response handshakes on idx 1 with cnt=2 -> cnt remains 2; rsp_ready_i=0 for 3 cycles -> slv_rsp_ready_o=0 and response held.
- rst_ni low for 1 cycle with cnt=3 -> cnt=0 next edge, all valid/ready outputs 0.

Source files
------------

// File: rtl/mem_demux.sv
// ----------------------------------------------------------------------------
// mem_demux
//
// Routes a single initiator request/response channel to one of NoPorts
// targets. The target index and decode-error flag come combinationally from an
// external address decoder. Responses stay in order because the demux locks
// onto one target (or onto the internal error responder) while any transaction
// is outstanding. A request to a different target waits until everything
// outstanding has drained.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_*_i / req_ready_o    initiator request channel (valid/ready)
//   req_idx_i, req_dec_err_i decoder result for req_addr_i
//   rsp_*_o / rsp_ready_i    initiator response channel (valid/ready)
//   slv_req_valid_o/ready_i  per-target request handshake
//   slv_req_addr_o etc.      request payload broadcast to all targets
//   slv_rsp_valid_i/ready_o  per-target response handshake
//   slv_rsp_rdata_i          per-target read data, port p in lane p
//   slv_rsp_err_i            per-target response error
// ----------------------------------------------------------------------------
module mem_demux #(
  parameter int unsigned           NoPorts   = 4,
  parameter int unsigned           AddrWidth = 32,
  parameter int unsigned           DataWidth = 32,
  parameter int unsigned           MaxTrans  = 4,
  parameter logic [DataWidth-1:0]  ErrData   = 32'hBADCAB1E,
  parameter int unsigned           IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // initiator request
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic                         req_we_i,
  input  logic [DataWidth-1:0]         req_wdata_i,
  input  logic [DataWidth/8-1:0]       req_wstrb_i,
  input  logic [IdxWidth-1:0]          req_idx_i,
  input  logic                         req_dec_err_i,
  // initiator response
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DataWidth-1:0]         rsp_rdata_o,
  output logic                         rsp_err_o,
  // target requests
  output logic [NoPorts-1:0]           slv_req_valid_o,
  input  logic [NoPorts-1:0]           slv_req_ready_i,
  output logic [AddrWidth-1:0]         slv_req_addr_o,
  output logic                         slv_req_we_o,
  output logic [DataWidth-1:0]         slv_req_wdata_o,
  output logic [DataWidth/8-1:0]       slv_req_wstrb_o,
  // target responses
  input  logic [NoPorts-1:0]           slv_rsp_valid_i,
  output logic [NoPorts-1:0]           slv_rsp_ready_o,
  input  logic [NoPorts*DataWidth-1:0] slv_rsp_rdata_i,
  input  logic [NoPorts-1:0]           slv_rsp_err_i
);

  localparam int unsigned           CntWidth   = $clog2(MaxTrans + 1);
  localparam logic [CntWidth-1:0]   CntMax     = CntWidth'(MaxTrans);
  localparam logic [IdxWidth:0]     NoPortsExt = (IdxWidth + 1)'(NoPorts);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic [IdxWidth-1:0] lock_idx_reg, lock_idx_next;
  logic                lock_err_reg, lock_err_next;

  // --------------------------------------------------------------------------
  // Per-port decode and response lane split
  // --------------------------------------------------------------------------
  logic [NoPorts-1:0]   req_sel;
  logic [NoPorts-1:0]   lock_sel;
  logic [DataWidth-1:0] rsp_rdata_lane [NoPorts];

  logic cnt_zero;
  logic cnt_full;
  logic match;
  logic acc;
  logic req_fwd;
  logic tgt_req_ready;
  logic req_ready;
  logic req_hs;

  logic                 lock_rsp_valid;
  logic                 lock_rsp_err;
  logic [DataWidth-1:0] lock_rdata;
  logic                 rsp_valid;
  logic                 rsp_fwd_ready;
  logic                 rsp_hs;

  for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
    assign req_sel[gi]         = (req_idx_i == IdxWidth'(gi));
    assign lock_sel[gi]        = (lock_idx_reg == IdxWidth'(gi));
    assign slv_req_valid_o[gi] = req_fwd && req_sel[gi];
    assign slv_rsp_ready_o[gi] = rsp_fwd_ready && lock_sel[gi];
    assign rsp_rdata_lane[gi]  = slv_rsp_rdata_i[gi*DataWidth +: DataWidth];
  end

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  assign cnt_zero = (cnt_reg == '0);
  assign cnt_full = (cnt_reg == CntMax);

  // A request may join the outstanding burst only if it goes to the locked
  // target; decode errors only join a burst that is already on the responder.
  assign match = req_dec_err_i ? lock_err_reg
                               : (!lock_err_reg && (req_idx_i == lock_idx_reg));

  assign acc = req_valid_i && (cnt_zero || (match && !cnt_full));

  // The valid never depends on the target's ready, so once raised it stays up
  // until the handshake: while waiting, cnt can only fall.
  assign req_fwd       = acc && !req_dec_err_i;
  assign tgt_req_ready = |(slv_req_ready_i & req_sel);
  assign req_ready     = acc && (req_dec_err_i || tgt_req_ready);
  assign req_ready_o   = req_ready;
  assign req_hs        = req_valid_i && req_ready;

  // Broadcast payload; only the selected target sees a valid.
  assign slv_req_addr_o  = req_addr_i;
  assign slv_req_we_o    = req_we_i;
  assign slv_req_wdata_o = req_wdata_i;
  assign slv_req_wstrb_o = req_wstrb_i;

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  always_comb begin
    lock_rdata = '0;
    for (int i = 0; i < NoPorts; i++) begin
      if (lock_sel[i]) begin
        lock_rdata = rsp_rdata_lane[i];
      end
    end
  end

  assign lock_rsp_valid = |(slv_rsp_valid_i & lock_sel);
  assign lock_rsp_err   = |(slv_rsp_err_i & lock_sel);

  // Gating with cnt keeps a stray target response from ever reaching the
  // initiator when nothing is outstanding.
  always_comb begin
    if (lock_err_reg) begin
      rsp_valid   = !cnt_zero;
      rsp_rdata_o = ErrData;
      rsp_err_o   = 1'b1;
    end else begin
      rsp_valid   = !cnt_zero && lock_rsp_valid;
      rsp_rdata_o = lock_rdata;
      rsp_err_o   = lock_rsp_err;
    end
  end

  assign rsp_valid_o   = rsp_valid;
  assign rsp_fwd_ready = rsp_ready_i && !cnt_zero && !lock_err_reg;
  assign rsp_hs        = rsp_valid && rsp_ready_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_next      = cnt_reg;
    lock_idx_next = lock_idx_reg;
    lock_err_next = lock_err_reg;

    if (req_hs) begin
      lock_idx_next = req_idx_i;
      lock_err_next = req_dec_err_i;
    end

    case ({req_hs, rsp_hs})
      2'b10:   cnt_next = cnt_reg + CntWidth'(1);
      2'b01:   cnt_next = cnt_reg - CntWidth'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      lock_idx_reg <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      lock_idx_reg <= lock_idx_next;
      lock_err_reg <= lock_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Interface checks
  // --------------------------------------------------------------------------
  a_idx_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && !req_dec_err_i) |-> ({1'b0, req_idx_i} < NoPortsExt));

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $past(req_valid_i && !req_ready) |->
      (req_valid_i && $stable(req_addr_i) && $stable(req_we_i) &&
       $stable(req_wdata_i) && $stable(req_wstrb_i) &&
       $stable(req_idx_i) && $stable(req_dec_err_i)));

  a_no_rsp_when_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_zero |-> (slv_rsp_valid_i == '0));

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_reg <= CntMax);

endmodule

// File: tb/tb_mem_demux.sv
module tb_mem_demux;

  localparam int          NP   = 4;
  localparam int          MAXT = 4;
  localparam logic [31:0] ERRD = 32'hBADCAB1E;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          req_we_i;
  logic [31:0]   req_wdata_i;
  logic [3:0]    req_wstrb_i;
  logic [1:0]    req_idx_i;
  logic          req_dec_err_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [3:0]    slv_req_valid_o;
  logic [3:0]    slv_req_ready_i;
  logic [31:0]   slv_req_addr_o;
  logic          slv_req_we_o;
  logic [31:0]   slv_req_wdata_o;
  logic [3:0]    slv_req_wstrb_o;
  logic [3:0]    slv_rsp_valid_i;
  logic [3:0]    slv_rsp_ready_o;
  logic [127:0]  slv_rsp_rdata_i;
  logic [3:0]    slv_rsp_err_i;

  mem_demux dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_we_i        (req_we_i),
    .req_wdata_i     (req_wdata_i),
    .req_wstrb_i     (req_wstrb_i),
    .req_idx_i       (req_idx_i),
    .req_dec_err_i   (req_dec_err_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .slv_req_valid_o (slv_req_valid_o),
    .slv_req_ready_i (slv_req_ready_i),
    .slv_req_addr_o  (slv_req_addr_o),
    .slv_req_we_o    (slv_req_we_o),
    .slv_req_wdata_o (slv_req_wdata_o),
    .slv_req_wstrb_o (slv_req_wstrb_o),
    .slv_rsp_valid_i (slv_rsp_valid_i),
    .slv_rsp_ready_o (slv_rsp_ready_o),
    .slv_rsp_rdata_i (slv_rsp_rdata_i),
    .slv_rsp_err_i   (slv_rsp_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the in-order list of transactions the initiator is owed.
  typedef struct packed {
    logic [1:0]  port;
    logic        err;    // decode error -> internal responder
    logic        serr;   // error bit the target will return
    logic [31:0] data;   // data the target will return
  } txn_t;

  txn_t        exp_q[$];
  int          tgt;
  bit          tgt_err;
  bit          hold;          // bench target is presenting a response
  int          rsp_mode;      // 0 never respond, 1 always, 2 random
  logic [31:0] nxt_data;
  bit          nxt_serr;
  bit          last_req_hs;
  int          rsp_count;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench targets: the target owning the oldest outstanding transaction
  // presents its response, holding it until accepted.
  task automatic drive_slaves();
    txn_t h;
    slv_rsp_valid_i = '0;
    slv_rsp_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    slv_rsp_err_i   = 4'($urandom);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      if (!h.err && (hold || rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 2) != 0))) begin
        slv_rsp_valid_i[h.port]              = 1'b1;
        slv_rsp_rdata_i[h.port*32 +: 32]     = h.data;
        slv_rsp_err_i[h.port]                = h.serr;
        hold                                 = 1'b1;
      end
    end
  endtask

  // One clock: check outputs against the model, advance the model at the edge,
  // then present target responses for the next cycle.
  task automatic tick();
    int         n;
    bit         same, acc, exp_rdy, exp_rv, rsp_hs;
    logic [3:0] exp_sv, exp_srr;
    txn_t       h, t;
    #1;
    last_req_hs = 1'b0;
    rsp_hs      = 1'b0;
    if (rst_ni) begin
      n       = exp_q.size();
      same    = (n == 0) || (req_dec_err_i ? tgt_err : (!tgt_err && int'(req_idx_i) == tgt));
      acc     = req_valid_i && (n == 0 || (same && n < MAXT));
      exp_sv  = (acc && !req_dec_err_i) ? (4'b0001 << req_idx_i) : 4'b0000;
      exp_rdy = acc && (req_dec_err_i || slv_req_ready_i[req_idx_i]);
      exp_rv  = 1'b0;
      if (n != 0) begin
        h      = exp_q[0];
        exp_rv = h.err || slv_rsp_valid_i[h.port];
      end
      exp_srr = (n != 0 && !tgt_err && rsp_ready_i) ? (4'b0001 << tgt) : 4'b0000;
      chk("req_ready", req_ready_o, exp_rdy);
      chk("slv_req_valid", slv_req_valid_o, exp_sv);
      chk("rsp_valid", rsp_valid_o, exp_rv);
      chk("slv_rsp_ready", slv_rsp_ready_o, exp_srr);
      chk("payload", {slv_req_addr_o, slv_req_wdata_o}, {req_addr_i, req_wdata_i});
      chk("payload_ctl", {slv_req_we_o, slv_req_wstrb_o}, {req_we_i, req_wstrb_i});
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata_o, h.err ? ERRD : h.data);
        chk("rsp_err", rsp_err_o, h.err ? 1'b1 : h.serr);
      end
      last_req_hs = req_valid_i && exp_rdy;
      rsp_hs      = exp_rv && rsp_ready_i;
    end
    @(posedge clk_i);
    if (!rst_ni) begin
      exp_q.delete();
      tgt     = 0;
      tgt_err = 1'b0;
      hold    = 1'b0;
    end else begin
      if (rsp_hs) begin
        h = exp_q.pop_front();
        rsp_count++;
        $display("rsp %0d: port=%0d decerr=%0d rdata=%h err=%0d", rsp_count, h.port, h.err,
                 h.err ? ERRD : h.data, h.err ? 1'b1 : h.serr);
        hold = 1'b0;
      end
      if (last_req_hs) begin
        t.port = req_idx_i;
        t.err  = req_dec_err_i;
        t.serr = nxt_serr;
        t.data = nxt_data;
        exp_q.push_back(t);
        tgt      = int'(req_idx_i);
        tgt_err  = req_dec_err_i;
        nxt_data = $urandom;
        nxt_serr = ($urandom_range(0, 7) == 0);
      end
    end
    @(negedge clk_i);
    drive_slaves();
  endtask

  task automatic set_req(input int idx, input bit dec);
    req_valid_i   = 1'b1;
    req_idx_i     = 2'(idx);
    req_dec_err_i = dec;
    req_addr_i    = $urandom;
    req_we_i      = 1'($urandom_range(0, 1));
    req_wdata_i   = $urandom;
    req_wstrb_i   = 4'($urandom);
  endtask

  task automatic wait_acc(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_req_hs && n < budget);
    chk("accept_bound", last_req_hs, 1'b1);
  endtask

  task automatic issue(input int idx, input bit dec);
    set_req(idx, dec);
    wait_acc(20);
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    rsp_mode    = 1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_bound", exp_q.size(), 0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    req_wdata_i = '0; req_wstrb_i = '0; req_idx_i = '0; req_dec_err_i = 1'b0;
    rsp_ready_i = 1'b1; slv_req_ready_i = 4'hF; slv_rsp_valid_i = '0;
    slv_rsp_rdata_i = '0; slv_rsp_err_i = '0;
    tgt = 0; tgt_err = 1'b0; hold = 1'b0; rsp_mode = 0; rsp_count = 0;
    nxt_data = $urandom; nxt_serr = 1'b0; last_req_hs = 1'b0;

    // Reset
    @(negedge clk_i);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_slv_req_valid", slv_req_valid_o, 4'b0000);
    chk("rst_slv_rsp_ready", slv_rsp_ready_o, 4'b0000);
    tick();

    // Single read to port 2, response one cycle later
    rsp_mode = 1; nxt_data = 32'h1234; nxt_serr = 1'b0;
    set_req(2, 1'b0);
    #1;
    chk("t1_slv_req_valid", slv_req_valid_o, 4'b0100);
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("t1_rsp_valid", rsp_valid_o, 1'b1);
    chk("t1_rdata", rsp_rdata_o, 32'h1234);
    chk("t1_err", rsp_err_o, 1'b0);
    tick();
    #1;
    chk("t1_idle_rsp_valid", rsp_valid_o, 1'b0);
    tick();

    // Fill to MaxTrans on port 1, fifth stalls until a response completes
    rsp_mode = 0;
    for (int i = 0; i < MAXT; i++) issue(1, 1'b0);
    set_req(1, 1'b0);
    #1;
    chk("t2_stall_5th", req_ready_o, 1'b0);
    tick();
    tick();
    rsp_mode = 1;
    wait_acc(10);
    req_valid_i = 1'b0;
    drain(40);

    // Target switch waits for the locked target to drain
    rsp_mode = 0;
    issue(3, 1'b0);
    issue(3, 1'b0);
    set_req(0, 1'b0);
    #1;
    chk("t3_switch_stall", slv_req_valid_o, 4'b0000);
    tick();
    tick();
    rsp_mode = 1;
    wait_acc(10);
    req_valid_i = 1'b0;
    drain(20);

    // Decode error goes to the internal responder
    rsp_ready_i = 1'b1;
    set_req(3, 1'b1);
    #1;
    chk("t4_dec_ready", req_ready_o, 1'b1);
    chk("t4_dec_slv_valid", slv_req_valid_o, 4'b0000);
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("t4_dec_rsp_valid", rsp_valid_o, 1'b1);
    chk("t4_dec_rdata", rsp_rdata_o, ERRD);
    chk("t4_dec_err", rsp_err_o, 1'b1);
    tick();

    // Held response, then simultaneous request and response handshakes
    rsp_mode = 0;
    issue(1, 1'b0);
    issue(1, 1'b0);
    rsp_mode = 1;
    rsp_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_slv_rsp_ready", slv_rsp_ready_o, 4'b0000);
      chk("t5_hold_rsp_valid", rsp_valid_o, 1'b1);
      tick();
    end
    rsp_mode = 0;
    rsp_ready_i = 1'b1;
    set_req(1, 1'b0);
    #1;
    chk("t5_simul_req_ready", req_ready_o, 1'b1);
    chk("t5_simul_rsp_valid", rsp_valid_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    issue(1, 1'b0);
    issue(1, 1'b0);
    set_req(1, 1'b0);
    #1;
    chk("t5_cnt_kept_full", req_ready_o, 1'b0);
    rsp_mode = 1;
    wait_acc(10);
    req_valid_i = 1'b0;
    drain(40);

    // Reset with three outstanding
    rsp_mode = 0;
    for (int i = 0; i < 3; i++) issue(2, 1'b0);
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    #1;
    chk("t6_rst_req_ready", req_ready_o, 1'b0);
    chk("t6_rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("t6_rst_slv_req_valid", slv_req_valid_o, 4'b0000);
    chk("t6_rst_slv_rsp_ready", slv_rsp_ready_o, 4'b0000);
    set_req(0, 1'b0);
    #1;
    chk("t6_post_rst_switch", slv_req_valid_o, 4'b0001);
    rsp_mode = 1;
    wait_acc(10);
    req_valid_i = 1'b0;
    drain(20);

    // Randomized traffic against the model
    rsp_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid_i || last_req_hs) begin
        if ($urandom_range(0, 3) != 0) set_req($urandom_range(0, NP - 1), $urandom_range(0, 7) == 0);
        else req_valid_i = 1'b0;
      end
      slv_req_ready_i = 4'($urandom);
      rsp_ready_i     = ($urandom_range(0, 3) != 0);
      tick();
    end
    if (req_valid_i && !last_req_hs) begin
      slv_req_ready_i = 4'hF;
      rsp_ready_i     = 1'b1;
      rsp_mode        = 1;
      wait_acc(20);
    end
    req_valid_i = 1'b0;
    drain(100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
